// File: rtl/vec_pkg.sv
// Shared constants and op encodings for the vector ALU pipeline.
package vec_pkg;

    localparam int unsigned LANES_DEF = 16;
    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_SUB = 2'b10,
        OP_ILL = 2'b11
    } op_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane signed add/multiply/subtract; result is the full-precision RW-bit value.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned RW    = 2 * WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic             active,
    output logic [RW-1:0]    res
);

    logic signed [RW-1:0] a_ext;
    logic signed [RW-1:0] b_ext;

    // Sign-extend up front so add/sub cannot overflow and the product is exact.
    assign a_ext = {{(RW-WIDTH){a[WIDTH-1]}}, a};
    assign b_ext = {{(RW-WIDTH){b[WIDTH-1]}}, b};

    always_comb begin
        res = '0;
        if (active) begin
            case (op)
                OP_ADD:  res = a_ext + b_ext;
                OP_MUL:  res = a_ext * b_ext;
                OP_SUB:  res = a_ext - b_ext;
                default: res = '0;
            endcase
        end
    end

endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage valid/ready vector ALU: S1 captures operands, S2 holds per-lane results.
module vector_alu_pipe
    import vec_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned RW    = 2 * WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*WIDTH-1:0]       a_data,
    input  logic [LANES*WIDTH-1:0]       b_data,
    input  logic [1:0]                   op,
    input  logic [$clog2(LANES+1)-1:0]   vlen,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*RW-1:0]          out_data,
    output logic                         out_err
);

    localparam int unsigned VW = $clog2(LANES + 1);

    logic                   s1_valid;
    logic [LANES*WIDTH-1:0] s1_a;
    logic [LANES*WIDTH-1:0] s1_b;
    op_e                    s1_op;
    logic [VW-1:0]          s1_vlen;

    logic                   s2_valid;
    logic [LANES*RW-1:0]    s2_data;
    logic                   s2_err;

    logic                   s2_load_c;
    logic                   s1_load_c;
    logic [VW-1:0]          eff_vlen_c;
    logic [LANES*RW-1:0]    lane_res_c;

    // Each stage advances when it is empty or its successor is taking its contents.
    assign s2_load_c = !s2_valid || out_ready;
    assign s1_load_c = !s1_valid || s2_load_c;
    assign in_ready  = s1_load_c;

    assign eff_vlen_c = (s1_vlen > VW'(LANES)) ? VW'(LANES) : s1_vlen;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic lane_active_c;
        assign lane_active_c = (VW'(i) < eff_vlen_c);

        vec_lane_alu #(
            .WIDTH (WIDTH),
            .RW    (RW)
        ) u_alu (
            .a      (s1_a[i*WIDTH +: WIDTH]),
            .b      (s1_b[i*WIDTH +: WIDTH]),
            .op     (s1_op),
            .active (lane_active_c),
            .res    (lane_res_c[i*RW +: RW])
        );
    end

    // Operand stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
            s1_vlen  <= '0;
        end else if (s1_load_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= a_data;
                s1_b    <= b_data;
                s1_op   <= op_e'(op);
                s1_vlen <= vlen;
            end
        end
    end

    // Result stage; contents only change when a valid beat moves in, so stalls hold output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
        end else if (s2_load_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= lane_res_c;
                s2_err  <= (s1_op == OP_ILL);
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_err   = s2_err;

endmodule
